// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pkg
// Brief    : Shared rate codes, default half-periods, FSM states and widths
//            for the LED blink scheduler.
// Revision : 1.0
// ============================================================================
package led_pkg;

    localparam int CNT_W = 25;

    localparam logic [1:0] RATE_100 = 2'b00;
    localparam logic [1:0] RATE_50  = 2'b01;
    localparam logic [1:0] RATE_10  = 2'b10;
    localparam logic [1:0] RATE_1   = 2'b11;

    // Half-periods at a 25 MHz clock, 50% duty.
    localparam int unsigned HALF_100_DEF = 125_000;
    localparam int unsigned HALF_50_DEF  = 250_000;
    localparam int unsigned HALF_10_DEF  = 1_250_000;
    localparam int unsigned HALF_1_DEF   = 12_500_000;
    localparam int unsigned GAP_DEF      = 12_500_000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/led_blink_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_scheduler_if
// Brief    : Request/field/status bundle between the status sources and the
//            LED blink scheduler.
// Revision : 1.0
// ============================================================================
interface led_blink_scheduler_if;

    logic       i_enable;
    logic       i_req_0;
    logic       i_req_1;
    logic [1:0] i_rate_0;
    logic [1:0] i_rate_1;
    logic [3:0] i_count_0;
    logic [3:0] i_count_1;
    logic [1:0] o_grant;
    logic [1:0] o_done;
    logic       o_busy;
    logic       o_led_drive;

    modport master (
        output i_enable, i_req_0, i_req_1, i_rate_0, i_rate_1, i_count_0, i_count_1,
        input  o_grant, o_done, o_busy, o_led_drive
    );

    modport slave (
        input  i_enable, i_req_0, i_req_1, i_rate_0, i_rate_1, i_count_0, i_count_1,
        output o_grant, o_done, o_busy, o_led_drive
    );

endinterface
`default_nettype wire

// File: rtl/led_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_rr_arbiter
// Brief    : Two-way round-robin arbiter; the pointer names the favoured
//            requester on a tie and moves to the loser on every grant.
// Revision : 1.0
// ============================================================================
module led_rr_arbiter (
    input  wire logic       i_clock,
    input  wire logic       i_reset,
    input  wire logic [1:0] i_req,
    input  wire logic       i_advance,
    output logic [1:0]      o_grant
);

    logic r_ptr;

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= o_grant[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_blink_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_scheduler
// Brief    : Shares one LED between two sources: arbitrates, plays an N-blink
//            burst at the latched rate, inserts a dark gap, then acknowledges.
// Revision : 1.0
// ============================================================================
module led_blink_scheduler
    import led_pkg::*;
#(
    parameter int unsigned HALF_100   = HALF_100_DEF,
    parameter int unsigned HALF_50    = HALF_50_DEF,
    parameter int unsigned HALF_10    = HALF_10_DEF,
    parameter int unsigned HALF_1     = HALF_1_DEF,
    parameter int unsigned GAP_CYCLES = GAP_DEF
) (
    input  wire logic               i_clock,
    input  wire logic               i_reset,
    led_blink_scheduler_if.slave    bus
);

    localparam int unsigned     c_cnt_limit = 32'd1 << CNT_W;
    localparam logic [CNT_W-1:0] c_h100_m1  = CNT_W'(HALF_100 - 1);
    localparam logic [CNT_W-1:0] c_h50_m1   = CNT_W'(HALF_50 - 1);
    localparam logic [CNT_W-1:0] c_h10_m1   = CNT_W'(HALF_10 - 1);
    localparam logic [CNT_W-1:0] c_h1_m1    = CNT_W'(HALF_1 - 1);
    localparam logic [CNT_W-1:0] c_gap_m1   = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

    if (HALF_100 == 0 || HALF_100 >= c_cnt_limit || HALF_50 == 0 || HALF_50 >= c_cnt_limit ||
        HALF_10 == 0 || HALF_10 >= c_cnt_limit || HALF_1 == 0 || HALF_1 >= c_cnt_limit ||
        GAP_CYCLES > c_cnt_limit) begin : g_bad_param
        $error("led_blink_scheduler: half-period or gap does not fit the phase counter");
    end

    function automatic logic [CNT_W-1:0] f_half_m1(input logic [1:0] rate);
        case (rate)
            RATE_100: return c_h100_m1;
            RATE_50:  return c_h50_m1;
            RATE_10:  return c_h10_m1;
            default:  return c_h1_m1;
        endcase
    endfunction

    state_t           r_state;
    logic [1:0]       r_grant;
    logic [1:0]       r_done;
    logic [1:0]       r_rate;
    logic             r_led;
    logic [CNT_W-1:0] r_phase;
    logic [3:0]       r_remaining;

    logic [1:0] w_req;
    logic [1:0] w_pick;
    logic [1:0] w_pick_rate;
    logic [3:0] w_pick_count;
    logic       w_advance;
    logic       w_abort;

    assign w_req        = {bus.i_req_1, bus.i_req_0};
    assign w_advance    = (r_state == ST_IDLE) && bus.i_enable && (w_req != 2'b00);
    assign w_pick_rate  = w_pick[1] ? bus.i_rate_1 : bus.i_rate_0;
    assign w_pick_count = w_pick[1] ? bus.i_count_1 : bus.i_count_0;
    // The owner withdrawing its request, or a global disable, cancels the burst.
    assign w_abort      = !bus.i_enable || ((w_req & r_grant) == 2'b00);

    led_rr_arbiter u_arb (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_req     (w_req),
        .i_advance (w_advance),
        .o_grant   (w_pick)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= 2'b00;
            r_done      <= 2'b00;
            r_rate      <= 2'b00;
            r_led       <= 1'b0;
            r_phase     <= '0;
            r_remaining <= 4'd0;
        end else begin
            r_done <= 2'b00;
            if (r_state == ST_IDLE) begin
                if (w_advance) begin
                    if (w_pick_count == 4'd0) begin
                        r_done <= w_pick;
                    end else begin
                        r_grant     <= w_pick;
                        r_rate      <= w_pick_rate;
                        r_remaining <= w_pick_count;
                        r_phase     <= f_half_m1(w_pick_rate);
                        r_led       <= 1'b1;
                        r_state     <= ST_ON;
                    end
                end
            end else if (w_abort) begin
                r_state <= ST_IDLE;
                r_led   <= 1'b0;
                r_grant <= 2'b00;
            end else if (r_phase != '0) begin
                r_phase <= r_phase - CNT_W'(1);
            end else begin
                case (r_state)
                    ST_ON: begin
                        r_led   <= 1'b0;
                        r_phase <= f_half_m1(r_rate);
                        r_state <= ST_OFF;
                    end
                    ST_OFF: begin
                        r_remaining <= r_remaining - 4'd1;
                        if (r_remaining != 4'd1) begin
                            r_led   <= 1'b1;
                            r_phase <= f_half_m1(r_rate);
                            r_state <= ST_ON;
                        end else if (GAP_CYCLES != 0) begin
                            r_phase <= c_gap_m1;
                            r_state <= ST_GAP;
                        end else begin
                            r_done  <= r_grant;
                            r_grant <= 2'b00;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_done  <= r_grant;
                        r_grant <= 2'b00;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_grant     = r_grant;
    assign bus.o_done      = r_done;
    assign bus.o_busy      = (r_state != ST_IDLE);
    assign bus.o_led_drive = r_led;

endmodule
`default_nettype wire
